// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiply/accumulate controller.
//   - LAT_DEFAULT : default multiplier pipeline depth (enabled cycles)
//   - op_e        : request opcodes (MTLO is intentionally absent)
//   - state_e     : controller FSM states
//   - hilo_op_e   : commands for the HI/LO register pair
//   - ext33()     : 32->33 bit operand extension for the signed multiplier
package mul_pkg;

    localparam int LAT_DEFAULT = 3;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MUL   = 3'd2,
        OP_MADD  = 3'd3,
        OP_MADDU = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MSUBU = 3'd6,
        OP_MTHI  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        HL_HOLD  = 3'd0,
        HL_LOAD  = 3'd1,
        HL_ADD   = 3'd2,
        HL_SUB   = 3'd3,
        HL_WR_HI = 3'd4
    } hilo_op_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // The external multiplier is signed 33x33, so unsigned operands get a
    // zero top bit and signed operands replicate bit 31.
    function automatic logic [32:0] ext33(input logic [31:0] x, input logic sgn);
        return {sgn & x[31], x};
    endfunction

endpackage

// File: rtl/hilo_acc.sv
// hilo_acc: architectural HI/LO register pair with load / accumulate /
// subtract / MTHI write.
//   clk, reset : clock and synchronous active-high reset (clears HI/LO)
//   op         : command for this edge (hold, load, add, sub, write HI)
//   p          : 64-bit product operand for load/add/sub
//   wdata      : value written to HI by the MTHI command
//   hi, lo     : current register contents
module hilo_acc
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  hilo_op_e    op,
    input  logic [63:0] p,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] hilo;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hilo <= '0;
        end else begin
            case (op)
                HL_LOAD:  hilo <= p;
                HL_ADD:   hilo <= hilo + p;   // wraps modulo 2^64
                HL_SUB:   hilo <= hilo - p;
                HL_WR_HI: hilo[63:32] <= wdata;
                default:  ;
            endcase
        end
    end

    assign hi = hilo[63:32];
    assign lo = hilo[31:0];

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller for an external pipelined signed 33x33
// multiplier, implementing MULT/MULTU/MUL/MADD(U)/MSUB(U)/MTHI.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/op/a/b      : request handshake and operands
//   req_ready             : request accepted when req_valid && req_ready
//   cancel                : flush; kills any in-flight operation
//   mul_en/mul_a/mul_b    : multiplier clock enable and extended operands
//   mul_res               : multiplier product (low 64 bits used)
//   busy                  : stall request while an operation is in flight
//   resp_valid, resp_gpr  : completion pulse and GPR result (MUL only)
//   hi, lo                : architectural HI/LO registers
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        req_ready,
    input  logic        cancel,
    output logic        mul_en,
    output logic [32:0] mul_a,
    output logic [32:0] mul_b,
    input  logic [65:0] mul_res,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_gpr,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_e      state;
    op_e         op_q;
    op_e         op_in;
    logic [CW-1:0] count;
    logic [32:0] a_q;
    logic [32:0] b_q;
    logic        accept;
    logic        in_sgn;
    logic [63:0] prod;
    hilo_op_e    hl_op;

    // Product bits above 63 carry no information for 32x32 results.
    logic        unused_res_msb;
    assign unused_res_msb = ^mul_res[65:64];

    assign op_in     = op_e'(req_op);
    assign in_sgn    = op_is_signed(op_in);
    assign req_ready = (state == ST_IDLE) && !cancel;
    assign accept    = req_valid && req_ready;
    assign prod      = mul_res[63:0];

    // Only an explicit RUN state can enable the multiplier; cancel gates it
    // in the same cycle so a flushed operation never advances the pipe.
    assign mul_en     = (state == ST_RUN) && !cancel;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign busy       = (state == ST_RUN) || (state == ST_DONE);
    assign resp_valid = (state == ST_DONE) && !cancel;
    assign resp_gpr   = ((state == ST_DONE) && (op_q == OP_MUL)) ? prod[31:0] : 32'd0;

    always_ff @(posedge clk) begin
        // NOTE: control registers are reset synchronously; reset outranks
        // cancel and any request on the same edge.
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (op_in != OP_MTHI)) begin
                        a_q   <= ext33(req_a, in_sgn);
                        b_q   <= ext33(req_b, in_sgn);
                        op_q  <= op_in;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                    end else if (count == CW'(LAT - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: hl_op gets a default before any branch so no latch is inferred.
    always_comb begin
        hl_op = HL_HOLD;
        if (accept && (op_in == OP_MTHI)) begin
            hl_op = HL_WR_HI;
        end else if ((state == ST_DONE) && !cancel) begin
            case (op_q)
                OP_MULT, OP_MULTU: hl_op = HL_LOAD;
                OP_MADD, OP_MADDU: hl_op = HL_ADD;
                OP_MSUB, OP_MSUBU: hl_op = HL_SUB;
                default:           hl_op = HL_HOLD;
            endcase
        end
    end

    hilo_acc u_hilo_acc (
        .clk   (clk),
        .reset (reset),
        .op    (hl_op),
        .p     (prod),
        .wdata (req_a),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;

    localparam int LAT = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;
    logic        cancel;
    logic        mul_en;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [65:0] mul_res;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_gpr;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, gpr, hi, lo;
    } vec_t;

    typedef struct {
        logic [31:0] gpr, hi, lo;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];

    mul_ctrl #(.LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .cancel     (cancel),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_res    (mul_res),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_gpr   (resp_gpr),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural external multiplier: LAT enabled stages, signed 33x33.
    logic [65:0] pipe [LAT];
    initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        if (mul_en) begin
            pipe[0] <= {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_res = pipe[LAT-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] tb_ext(input logic [2:0] op, input logic [31:0] x);
        logic sgn;
        sgn = (op == 3'd0) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
        return sgn ? {x[31], x} : {1'b0, x};
    endfunction

    // Drive one request at the current cycle T and follow it to completion.
    task automatic run_op(input vec_t v);
        int   n;
        int   en_cnt;
        exp_t e;
        req_valid = 1'b1; req_op = v.op; req_a = v.a; req_b = v.b;
        #1;
        check("req_ready", req_ready, 1);
        if (v.op == 3'd7) begin
            cyc(); req_valid = 1'b0; #1;
            check("mthi_busy", busy, 0);
            check("mthi_resp_valid", resp_valid, 0);
            check("mthi_hi", hi, v.hi);
            check("mthi_lo", lo, v.lo);
            return;
        end
        sb.push_back('{v.gpr, v.hi, v.lo});
        cyc(); req_valid = 1'b0; #1;                 // cycle T+1
        check("mul_a_ext", mul_a, tb_ext(v.op, v.a));
        check("mul_b_ext", mul_b, tb_ext(v.op, v.b));
        n = 1;
        en_cnt = 0;
        while (!resp_valid && n < 20) begin
            check("busy_run", busy, 1);
            if (mul_en) en_cnt++;
            cyc(); #1;
            n++;
        end
        check("resp_latency", n, LAT + 1);
        check("mul_en_cycles", en_cnt, LAT);
        if (resp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_gpr", resp_gpr, e.gpr);
            check("done_busy", busy, 1);
            check("done_mul_en", mul_en, 0);
            cyc(); #1;
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            check("idle_busy", busy, 0);
            check("idle_resp_valid", resp_valid, 0);
            check("idle_ready", req_ready, 1);
        end
    endtask

    initial begin
        vec_t v;
        // op, a, b, gpr, hi, lo (HI/LO accumulate across rows)
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'd2, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 32'hFFFFFFFE, 32'h00000001};
        vecs[3]  = '{3'd1, 32'd4,        32'd4,        32'd0,        32'h00000000, 32'h00000010};
        vecs[4]  = '{3'd6, 32'd3,        32'd8,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFF8};
        vecs[5]  = '{3'd3, 32'd2,        32'd4,        32'd0,        32'h00000000, 32'h00000000};
        vecs[6]  = '{3'd7, 32'h1234,     32'd0,        32'd0,        32'h00001234, 32'h00000000};
        vecs[7]  = '{3'd4, 32'h80000000, 32'd2,        32'd0,        32'h00001235, 32'h00000000};
        vecs[8]  = '{3'd5, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h00001235, 32'h00000001};
        vecs[9]  = '{3'd3, 32'h80000000, 32'h80000000, 32'd0,        32'h40001235, 32'h00000001};
        vecs[10] = '{3'd0, 32'h80000000, 32'h7FFFFFFF, 32'd0,        32'hC0000000, 32'h80000000};
        vecs[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hC0000000, 32'h80000000};

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; cancel = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mul_en", mul_en, 0);
        check("rst_resp_gpr", resp_gpr, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Cancel during RUN: MULT accepted at T, cancel at T+2.
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd6; #1;
        check("cx_ready", req_ready, 1);
        cyc(); req_valid = 1'b0;                     // T+1
        check("cx_resp_t1", resp_valid, 0);
        cyc(); cancel = 1'b1; #1;                    // T+2
        check("cx_mul_en", mul_en, 0);
        check("cx_resp_t2", resp_valid, 0);
        check("cx_ready_blocked", req_ready, 0);
        cyc(); cancel = 1'b0; #1;                    // T+3
        check("cx_busy", busy, 0);
        check("cx_resp_t3", resp_valid, 0);
        check("cx_hi", hi, 32'hC0000000);
        check("cx_lo", lo, 32'h80000000);
        v = '{3'd1, 32'd5, 32'd5, 32'd0, 32'h0, 32'h19};
        run_op(v);

        // Cancel during DONE: no response, no HI/LO update.
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'd3; req_b = 32'd3; #1;
        cyc(); req_valid = 1'b0;
        repeat (LAT) cyc();                          // now T+LAT+1 (DONE)
        cancel = 1'b1; #1;
        check("cd_busy", busy, 1);
        check("cd_resp_valid", resp_valid, 0);
        check("cd_mul_en", mul_en, 0);
        cyc(); cancel = 1'b0; #1;
        check("cd_idle", busy, 0);
        check("cd_hi", hi, 32'h0);
        check("cd_lo", lo, 32'h19);

        // Reset at T+3 of MADD abandons it and clears HI/LO.
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'd2; req_b = 32'd2; #1;
        cyc(); req_valid = 1'b0;                     // T+1
        cyc(); cyc();                                // T+3
        reset = 1'b1;
        cyc(); reset = 1'b0; #1;                     // T+4
        check("rr_hi", hi, 0);
        check("rr_lo", lo, 0);
        check("rr_ready", req_ready, 1);
        check("rr_busy", busy, 0);
        check("rr_resp_valid", resp_valid, 0);
        check("rr_mul_en", mul_en, 0);
        check("rr_mul_a", mul_a, 0);

        // MTHI with cancel in the same cycle is dropped.
        req_valid = 1'b1; req_op = 3'd7; req_a = 32'h1234; cancel = 1'b1; #1;
        check("mc_ready", req_ready, 0);
        cyc(); req_valid = 1'b0; cancel = 1'b0; #1;
        check("mc_hi", hi, 0);

        v = '{3'd7, 32'h55, 32'd0, 32'd0, 32'h55, 32'h0};
        run_op(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 Parameter LAT, default 3, multiplier pipeline depth in clock-enabled cycles.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present; req_op  in  3  operation code; req_a, req_b  in  32 each  rs/rt operands.
REQ-005 req_ready  out  1  request accepted this cycle when req_valid && req_ready.
REQ-006 cancel  in  1  exception/flush; kills any in-flight operation.
REQ-007 mul_en  out  1; mul_a, mul_b  out  33 each; mul_res  in  66 (signed 33x33 multiplier port).
REQ-008 busy  out  1  pipeline stall request; resp_valid  out  1  one-cycle completion pulse; resp_gpr  out  32  GPR result for MUL.
REQ-009 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-010 Opcodes: MULT=0, MULTU=1, MUL=2, MADD=3, MADDU=4, MSUB=5, MSUBU=6, MTHI=7; MTLO unsupported; MTHI writes req_a to HI.
REQ-011 FSM states IDLE, RUN, DONE; req_ready = (state==IDLE) && !cancel.
REQ-012 IDLE: accepted multiply op (0-6) registers operands/op and goes to RUN with count=0; accepted MTHI writes HI at that edge and stays IDLE, resp_valid=0.
REQ-013 Operand extension: signed ops (MULT, MUL, MADD, MSUB) sign-extend bit 31 to 33 bits; unsigned ops (MULTU, MADDU, MSUBU) zero-extend.
REQ-014 RUN: mul_en=1, mul_a/mul_b driven from registered operands; count increments each cycle; after LAT cycles in RUN go to DONE.
REQ-015 Accept at cycle T -> RUN cycles T+1..T+LAT, DONE at T+LAT+1; mul_en=0 in IDLE and DONE.
REQ-016 DONE: product P = mul_res[63:0]; resp_valid=1 for exactly that cycle; next state IDLE.
REQ-017 DONE writes at the closing edge: MULT/MULTU {HI,LO}=P; MADD/MADDU {HI,LO}+=P; MSUB/MSUBU {HI,LO}-=P (64-bit, wrap modulo 2^64); MUL leaves HI/LO unchanged.
REQ-018 resp_gpr = P[31:0] in DONE for MUL, 0 otherwise and in every other state.
REQ-019 busy = (state==RUN) || (state==DONE); busy=0 in IDLE.
REQ-020 cancel in RUN or DONE: next state IDLE, no HI/LO write, resp_valid forced 0 that cycle, mul_en forced 0 that cycle.
REQ-021 cancel with req_valid in IDLE: request not accepted (cancel wins), MTHI not written.
REQ-022 hi/lo outputs reflect register contents; updates visible the cycle after the write edge.
REQ-023 Undefined internal state never produces mul_en=1 outside RUN.

Reset
REQ-024 reset has priority over cancel and requests; next state IDLE, count=0, HI=0, LO=0.
REQ-025 After reset: req_ready=1, busy=0, resp_valid=0, mul_en=0, resp_gpr=0, mul_a=mul_b=0.
REQ-026 reset mid-RUN/DONE abandons the operation with no HI/LO write.

Structure
REQ-027 Opcode constants, FSM state encodings and LAT default live in the shared mul package (mul_pkg).
REQ-028 One sub-module natural: hilo_acc (64-bit HI/LO register with load/add/sub/MTHI write); FSM and extension stay in mul_ctrl.
REQ-029 Multiplier itself is external, connected via mul_en/mul_a/mul_b/mul_res.

Verification
REQ-030 MULT a=0xFFFFFFFE, b=3 accepted T -> mul_a=0x1FFFFFFFE, busy T+1..T+4, resp_valid T+4, HI=0xFFFFFFFF LO=0xFFFFFFFA at T+5.
REQ-031 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 MUL a=7, b=-6 -> resp_gpr=0xFFFFFFD6 in DONE cycle, HI/LO unchanged.
REQ-033 HI:LO=0x0:0x10, MSUBU a=3 b=8 -> HI=0xFFFFFFFF LO=0xFFFFFFF8; then MADD a=2 b=4 -> HI=0 LO=0.
REQ-034 MULT accepted, cancel at T+2 -> IDLE at T+3, no resp_valid, HI/LO unchanged, next request accepted T+3.
REQ-035 reset at T+3 of MADD -> HI=LO=0, req_ready=1 next cycle; MTHI 0x1234 with cancel same cycle -> HI unchanged.
